// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Constants shared by the pipelined core's front-end and datapath.
//   XLEN          : address / instruction word width
//   RESET_VECTOR  : address fetched first after reset
//   INSTR_NOP     : canonical NOP encoding (addi x0, x0, 0)
//   PC_INCR       : sequential fetch stride in bytes
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam int          PC_INCR      = 4;

endpackage : cpu_pkg

// File: rtl/instr_prefetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
//   Synchronous FIFO of {pc, instr} pairs with a single-cycle flush.
//   The head entry is presented combinationally from the storage array, so an
//   entry pushed on one edge is visible at the head right after that edge.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset (empties the FIFO)
//   flush_i        in   empty the FIFO on this edge (push/pop ignored)
//   push_i         in   write {push_pc_i, push_instr_i}; ignored when full
//   push_pc_i      in   XLEN pc of the pushed entry
//   push_instr_i   in   XLEN instruction of the pushed entry
//   pop_i          in   drop the head entry; ignored when empty
//   valid_o        out  FIFO not empty
//   head_pc_o      out  pc of head entry (0 when empty)
//   head_instr_o   out  instruction of head entry (0 when empty)
//   level_o        out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module prefetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [XLEN-1:0] push_instr_i,
    input  logic            pop_i,
    output logic            valid_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [LW-1:0]   level_o
);

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic w_not_full;
    logic w_not_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_not_full  = (r_level != LW'(DEPTH));
    assign w_not_empty = (r_level != '0);
    assign w_do_push   = push_i & w_not_full;
    assign w_do_pop    = pop_i & w_not_empty;

    // Storage carries no reset: pointers and level define what is live.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_pc_mem[r_wr_ptr]    <= push_pc_i;
            r_instr_mem[r_wr_ptr] <= push_instr_i;
        end
    end

    // Pointers are power-of-two sized and wrap naturally; the separate level
    // counter disambiguates full from empty.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head reads as zero when empty so stale RAM contents never leak out.
    assign valid_o      = w_not_empty;
    assign head_pc_o    = w_not_empty ? r_pc_mem[r_rd_ptr]    : '0;
    assign head_instr_o = w_not_empty ? r_instr_mem[r_rd_ptr] : '0;
    assign level_o      = r_level;

endmodule : prefetch_fifo

// File: rtl/instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit
//   Fetch front-end: issues sequential instruction-memory reads into a
//   DEPTH-entry prefetch queue and hands {pc, instr} to decode.
//
//   Handshakes: a transfer happens on a rising edge when the producer's valid
//   (or rd) and the consumer's ready are both high in that cycle. Memory side:
//   instr_mem_rd_o & instr_mem_ready_i, data valid in the same cycle. Decode
//   side: instr_valid_o & instr_ready_i. A redirect flushes the queue and
//   restarts fetch at the target; no fetch is issued in the redirect cycle.
//
// Ports
//   clk_i              in   clock
//   rst_i              in   synchronous active-high reset
//   instr_mem_addr_o   out  fetch address (word aligned)
//   instr_mem_rd_o     out  fetch request
//   instr_mem_ready_i  in   memory accepts request this cycle
//   instr_mem_data_i   in   instruction word at instr_mem_addr_o
//   redirect_i         in   flush and restart fetch
//   redirect_addr_i    in   restart target, bits [1:0] ignored
//   instr_valid_o      out  queue head valid
//   instr_ready_i      in   decode accepts head
//   instr_o            out  head instruction
//   instr_pc_o         out  head instruction address
//   level_o            out  queue occupancy
// ---------------------------------------------------------------------------
module instr_prefetch_unit #(
    parameter int               XLEN     = cpu_pkg::XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(cpu_pkg::RESET_VECTOR),
    localparam int              LW       = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] instr_mem_addr_o,
    output logic            instr_mem_rd_o,
    input  logic            instr_mem_ready_i,
    input  logic [XLEN-1:0] instr_mem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [LW-1:0]   level_o
);

    import cpu_pkg::*;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic [LW-1:0]   w_level;
    logic            w_fifo_valid;
    logic            w_fetch_rd;
    logic            w_fetch_accept;
    logic            w_deq;

    assign w_redirect_pc = redirect_addr_i & ~XLEN'(3);

    // Full check uses the registered level only, so instr_ready_i has no
    // combinational path to the memory request.
    assign w_fetch_rd     = ~rst_i & ~redirect_i & (w_level != LW'(DEPTH));
    assign w_fetch_accept = w_fetch_rd & instr_mem_ready_i;
    assign w_deq          = w_fifo_valid & instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_fetch_accept) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(PC_INCR);
        end
    end

    prefetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .push_i       (w_fetch_accept),
        .push_pc_i    (r_fetch_pc),
        .push_instr_i (instr_mem_data_i),
        .pop_i        (w_deq),
        .valid_o      (w_fifo_valid),
        .head_pc_o    (instr_pc_o),
        .head_instr_o (instr_o),
        .level_o      (w_level)
    );

    assign instr_mem_addr_o = r_fetch_pc;
    assign instr_mem_rd_o   = w_fetch_rd;
    assign instr_valid_o    = w_fifo_valid;
    assign level_o          = w_level;

endmodule : instr_prefetch_unit

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          LW       = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_PC = 32'h0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst         = 1'b1;
    logic            mem_ready   = 1'b0;
    logic            redirect    = 1'b0;
    logic [XLEN-1:0] redirect_addr = '0;
    logic            ready       = 1'b0;

    logic [XLEN-1:0] mem_addr;
    logic            mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [LW-1:0]   level;

    // Memory model: instruction word is its address plus 0x1000.
    assign mem_data = mem_addr + 32'h1000;

    instr_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_mem_addr_o  (mem_addr),
        .instr_mem_rd_o    (mem_rd),
        .instr_mem_ready_i (mem_ready),
        .instr_mem_data_i  (mem_data),
        .redirect_i        (redirect),
        .redirect_addr_i   (redirect_addr),
        .instr_valid_o     (valid),
        .instr_ready_i     (ready),
        .instr_o           (instr),
        .instr_pc_o        (instr_pc),
        .level_o           (level)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- scoreboard ----------------
    logic [2*XLEN-1:0] exp_q[$];
    logic [XLEN-1:0]   model_pc = RESET_PC;
    logic              mon_en   = 1'b0;
    logic              exp_rd;
    logic              exp_valid;
    logic [2*XLEN-1:0] exp_head;

    // Checks the DUT against the model at mid-cycle, then advances the model
    // by what the coming rising edge will do with the current inputs.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rd    = !rst && !redirect && (exp_q.size() != DEPTH);
            exp_valid = (exp_q.size() != 0);
            exp_head  = exp_valid ? exp_q[0] : '0;

            checks++;
            if (mem_rd !== exp_rd) begin
                errors++;
                $display("FAIL sb_rd t=%0t got=%b exp=%b", $time, mem_rd, exp_rd);
            end
            checks++;
            if (mem_addr !== model_pc) begin
                errors++;
                $display("FAIL sb_addr t=%0t got=%h exp=%h", $time, mem_addr, model_pc);
            end
            checks++;
            if (level !== LW'(exp_q.size())) begin
                errors++;
                $display("FAIL sb_level t=%0t got=%0d exp=%0d", $time, level, exp_q.size());
            end
            checks++;
            if (valid !== exp_valid) begin
                errors++;
                $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, valid, exp_valid);
            end
            checks++;
            if ({instr_pc, instr} !== exp_head) begin
                errors++;
                $display("FAIL sb_head t=%0t got=%h/%h exp=%h/%h", $time, instr_pc, instr,
                         exp_head[2*XLEN-1:XLEN], exp_head[XLEN-1:0]);
            end

            if (rst) begin
                exp_q.delete();
                model_pc = RESET_PC;
            end else if (redirect) begin
                exp_q.delete();
                model_pc = redirect_addr & ~32'h3;
            end else begin
                if (exp_valid && ready) void'(exp_q.pop_front());
                if (exp_rd && mem_ready) begin
                    exp_q.push_back({model_pc, model_pc + 32'h1000});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic mr, input logic rdy);
        @(posedge clk); #1;
        rst = 1'b1; redirect = 1'b0; mem_ready = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = mr; ready = rdy;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got=%b exp=0", mem_rd); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if (instr !== '0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rst_rd1 got=%b exp=1", mem_rd); end
    endtask

    task automatic test_stream();
        @(posedge clk); #1 mem_ready = 1'b1; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(4 * i + 32'h1000)) begin
                errors++;
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, valid, instr_pc, instr,
                         32'(4 * i), 32'(4 * i + 32'h1000));
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL full_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL full_addr got=%h exp=10", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h10 || level !== LW'(4)) begin
            errors++; $display("FAIL full_hold got=%h/%0d exp=10/4", mem_addr, level);
        end
        @(posedge clk); #1 ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (instr_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL drain_%0d got=%h exp=%h", i, instr_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_mem_stall();
        do_reset(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b0; ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_addr !== 32'h8 || mem_rd !== 1'b1 || level !== LW'(2 - k)) begin
                errors++;
                $display("FAIL mstall_%0d got=%h/%b/%0d exp=8/1/%0d", k, mem_addr, mem_rd, level, 2 - k);
            end
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || instr_pc !== 32'h8) begin
            errors++; $display("FAIL mstall_resume got=%b/%h exp=1/8", valid, instr_pc);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 redirect = 1'b1; redirect_addr = 32'h103;
        @(negedge clk);
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir_rd got=%b exp=0", mem_rd); end
        @(posedge clk); #1 redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++; if (level !== '0 || valid !== 1'b0) begin
            errors++; $display("FAIL redir_flush got=%0d/%b exp=0/0", level, valid);
        end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%h exp=100", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h1100) begin
            errors++; $display("FAIL redir_head got=%b/%h/%h exp=1/100/1100", valid, instr_pc, instr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (level !== LW'(3) || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rmid_pre got=%0d/%b exp=3/0", level, mem_rd);
        end
        @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (level !== '0 || valid !== 1'b0 || mem_addr !== RESET_PC) begin
            errors++; $display("FAIL rmid_post got=%0d/%b/%h exp=0/0/%h", level, valid, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF; mem_ready = 1'b1; ready = 1'b1;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got=%h exp=fffffffc", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", mem_addr); end
        checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h0000_0FFC) begin
            errors++; $display("FAIL wrap_head got=%h/%h exp=fffffffc/00000ffc", instr_pc, instr);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 99) == 0);
            mem_ready     = ($urandom_range(0, 3) != 0);
            ready         = ($urandom_range(0, 2) != 0);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_addr = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0; ready = 1'b0; redirect = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_mem_stall();
        test_redirect();
        test_reset_mid();
        test_wrap();
        test_random();
        @(posedge clk); #1 mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_prefetch_unit
